// File: rtl/lsc_mc_arbiter.sv
// Multi-channel load/store arbiter: round-robin picks one core channel and
// serialises its header plus write beats onto the DMA stream, routing read beats back.
module lsc_mc_arbiter #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned DW      = 128,
  parameter int unsigned HADDR_W = 40,
  parameter int unsigned LADDR_W = 14,
  parameter int unsigned LEN_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         ch_req,
  input  logic [NCH-1:0]         ch_rwn,
  input  logic [NCH*HADDR_W-1:0] ch_host_addr,
  input  logic [NCH*LADDR_W-1:0] ch_local_addr,
  input  logic [NCH*LEN_W-1:0]   ch_len,
  output logic [NCH-1:0]         ch_grant,
  output logic [NCH-1:0]         ch_done,
  input  logic [NCH*DW-1:0]      ch_wdata,
  input  logic [NCH-1:0]         ch_wdata_valid,
  output logic [NCH-1:0]         ch_wdata_ready,
  output logic [DW-1:0]          ch_rdata,
  output logic [NCH-1:0]         ch_rdata_valid,
  input  logic [NCH-1:0]         ch_rdata_ready,
  output logic                   busy,
  output logic                   dma_req,
  input  logic                   dma_resp,
  output logic                   dma_write_valid,
  output logic [DW-1:0]          dma_write_data,
  input  logic                   dma_write_ready,
  input  logic                   dma_read_valid,
  input  logic [DW-1:0]          dma_read_data,
  output logic                   dma_read_ready
);

  localparam int unsigned GW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned HDR_W = 8 + LEN_W + HADDR_W + LADDR_W;
  localparam logic [7:0]  OP_WR = 8'h03;
  localparam logic [7:0]  OP_RD = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_HDR   = 3'd2,
    S_WDATA = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        gnt_q, gnt_d;
  logic [GW-1:0]        last_q, last_d;
  logic                 rwn_q, rwn_d;
  logic [HADDR_W-1:0]   host_q, host_d;
  logic [LADDR_W-1:0]   lcl_q, lcl_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;

  logic [HADDR_W-1:0]   host_a  [NCH];
  logic [LADDR_W-1:0]   lcl_a   [NCH];
  logic [LEN_W-1:0]     len_a   [NCH];
  logic [DW-1:0]        wdata_a [NCH];

  logic [GW-1:0]        pick;
  logic [GW-1:0]        cand;
  logic                 pick_vld;
  logic [NCH-1:0]       grant_oh;
  logic [HDR_W-1:0]     hdr_word;
  logic                 last_beat;

  // Unpack the per-channel buses
  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      host_a[i]  = ch_host_addr[i*HADDR_W +: HADDR_W];
      lcl_a[i]   = ch_local_addr[i*LADDR_W +: LADDR_W];
      len_a[i]   = ch_len[i*LEN_W +: LEN_W];
      wdata_a[i] = ch_wdata[i*DW +: DW];
    end
  end

  // Round-robin: first requester after the previous owner wins
  always_comb begin
    pick     = '0;
    cand     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = GW'((32'(last_q) + i) % NCH);
      if (!pick_vld && ch_req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign grant_oh  = NCH'(1) << gnt_q;
  assign hdr_word  = {(rwn_q ? OP_RD : OP_WR), len_q, host_q, lcl_q};
  assign last_beat = (cnt_q == len_q - LEN_W'(1));
  assign ch_rdata  = dma_read_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= GW'(NCH - 1);
      rwn_q   <= 1'b0;
      host_q  <= '0;
      lcl_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rwn_q   <= rwn_d;
      host_q  <= host_d;
      lcl_q   <= lcl_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and stream steering; only the owner's ready/valid lines ever move
  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    last_d          = last_q;
    rwn_d           = rwn_q;
    host_d          = host_q;
    lcl_d           = lcl_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    ch_grant        = '0;
    ch_done         = '0;
    ch_wdata_ready  = '0;
    ch_rdata_valid  = '0;
    busy            = (state_q != S_IDLE);
    dma_req         = 1'b0;
    dma_write_valid = 1'b0;
    dma_write_data  = '0;
    dma_read_ready  = 1'b0;

    if (state_q != S_IDLE) ch_grant = grant_oh;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick;
          rwn_d   = ch_rwn[pick];
          host_d  = host_a[pick];
          lcl_d   = lcl_a[pick];
          len_d   = len_a[pick];
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        dma_req = 1'b1;
        if (dma_resp) state_d = S_HDR;
      end
      S_HDR: begin
        dma_write_valid = 1'b1;
        dma_write_data  = DW'(hdr_word);
        if (dma_write_ready) begin
          cnt_d = '0;
          if (len_q == '0)  state_d = S_DONE;
          else if (rwn_q)   state_d = S_RDATA;
          else              state_d = S_WDATA;
        end
      end
      S_WDATA: begin
        dma_write_valid       = ch_wdata_valid[gnt_q];
        dma_write_data        = wdata_a[gnt_q];
        ch_wdata_ready[gnt_q] = dma_write_ready;
        if (ch_wdata_valid[gnt_q] && dma_write_ready) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (last_beat) state_d = S_DONE;
        end
      end
      S_RDATA: begin
        ch_rdata_valid[gnt_q] = dma_read_valid;
        dma_read_ready        = ch_rdata_ready[gnt_q];
        if (dma_read_valid && ch_rdata_ready[gnt_q]) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (last_beat) state_d = S_DONE;
        end
      end
      S_DONE: begin
        ch_done = grant_oh;
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsc_mc_arbiter.sv
// Directed bench for lsc_mc_arbiter: four channels, 4-bit lengths so the
// maximum-length burst is short enough to run in full.
module tb_lsc_mc_arbiter;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 128;
  localparam int unsigned HW  = 40;
  localparam int unsigned LW  = 14;
  localparam int unsigned NW  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_rwn;
  logic [NCH*HW-1:0] ch_host_addr;
  logic [NCH*LW-1:0] ch_local_addr;
  logic [NCH*NW-1:0] ch_len;
  logic [NCH-1:0]    ch_grant;
  logic [NCH-1:0]    ch_done;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH-1:0]    ch_wdata_valid;
  logic [NCH-1:0]    ch_wdata_ready;
  logic [DW-1:0]     ch_rdata;
  logic [NCH-1:0]    ch_rdata_valid;
  logic [NCH-1:0]    ch_rdata_ready;
  logic              busy;
  logic              dma_req;
  logic              dma_resp;
  logic              dma_write_valid;
  logic [DW-1:0]     dma_write_data;
  logic              dma_write_ready;
  logic              dma_read_valid;
  logic [DW-1:0]     dma_read_data;
  logic              dma_read_ready;

  lsc_mc_arbiter #(.NCH(NCH), .DW(DW), .HADDR_W(HW), .LADDR_W(LW), .LEN_W(NW)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_rwn(ch_rwn),
    .ch_host_addr(ch_host_addr), .ch_local_addr(ch_local_addr), .ch_len(ch_len),
    .ch_grant(ch_grant), .ch_done(ch_done), .ch_wdata(ch_wdata),
    .ch_wdata_valid(ch_wdata_valid), .ch_wdata_ready(ch_wdata_ready),
    .ch_rdata(ch_rdata), .ch_rdata_valid(ch_rdata_valid), .ch_rdata_ready(ch_rdata_ready),
    .busy(busy), .dma_req(dma_req), .dma_resp(dma_resp),
    .dma_write_valid(dma_write_valid), .dma_write_data(dma_write_data),
    .dma_write_ready(dma_write_ready), .dma_read_valid(dma_read_valid),
    .dma_read_data(dma_read_data), .dma_read_ready(dma_read_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] hdr(input bit rd, input logic [3:0] len,
                                       input logic [39:0] host, input logic [13:0] lcl);
    return {62'b0, (rd ? 8'h01 : 8'h03), len, host, lcl};
  endfunction

  function automatic logic [127:0] wbeat(input int ch, input int k);
    return {64'hDA7A_0000_C0DE_0000, 32'(ch), 32'(k)};
  endfunction

  function automatic logic [127:0] rbeat(input int ch, input int k);
    return {64'hBEEF_0000_F00D_0000, 32'(ch), 32'(k)};
  endfunction

  // Stream monitor: accepted DMA words, done pulses and protocol flags
  logic [127:0] wq[$];
  logic [127:0] rq[$];
  int           done_cnt[NCH];
  int           rv_bad = 0;
  int           rv0    = 0;
  int           stab_err = 0;
  bit           prev_stall = 1'b0;
  logic [127:0] prev_data  = '0;

  initial for (int i = 0; i < int'(NCH); i++) done_cnt[i] = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (dma_write_valid && dma_write_ready) wq.push_back(dma_write_data);
      if (dma_read_valid && dma_read_ready)   rq.push_back(dma_read_data);
      for (int i = 0; i < int'(NCH); i++) done_cnt[i] += int'(ch_done[i]);
      if ((ch_rdata_valid & ~ch_grant) != '0) rv_bad++;
      if (ch_rdata_valid[0]) rv0++;
      if (prev_stall && dma_write_valid && dma_write_data !== prev_data) stab_err++;
      prev_stall = dma_write_valid && !dma_write_ready;
      prev_data  = dma_write_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // mode 0: no stalls, 1: random gaps both sides, 2: five-cycle write stalls on header and mid-burst
  task automatic xfer(input int ch, input bit rd, input logic [3:0] len, input logic [39:0] host,
                      input logic [13:0] lcl, input int resp_dly, input int mode);
    int wb = 0, rb = 0, last_cyc = -1, done_cyc = -1, d0;
    bit hdr_acc = 1'b0;
    logic [127:0] eh;
    eh = hdr(rd, len, host, lcl);
    wq.delete();
    rq.delete();
    d0 = done_cnt[ch];
    ch_rwn[ch] = rd;
    ch_host_addr[ch*HW +: HW]  = host;
    ch_local_addr[ch*LW +: LW] = lcl;
    ch_len[ch*NW +: NW]        = len;
    ch_req[ch] = 1'b1;
    tick();
    check("grant", 128'(ch_grant), 128'(1) << ch);
    ch_req[ch] = 1'b0;
    repeat (resp_dly) begin
      check("dma_req_hold", 128'(dma_req), 128'(1));
      tick();
    end
    dma_resp = 1'b1;
    tick();
    dma_resp = 1'b0;
    ch_rdata_ready = '1;
    dma_read_valid = 1'b1;
    #1;
    check("hdr_valid", 128'(dma_write_valid), 128'(1));
    check("hdr_word", dma_write_data, eh);
    check("hdr_no_rd", 128'({dma_read_ready, ch_rdata_valid}), 128'(0));
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (ch_done[ch]) begin
        done_cyc = cyc;
        break;
      end
      case (mode)
        1:       dma_write_ready = 1'($urandom_range(0, 1));
        2:       dma_write_ready = !((cyc < 5) || (cyc >= 7 && cyc < 12));
        default: dma_write_ready = 1'b1;
      endcase
      ch_wdata_valid[ch]      = !rd && (mode != 1 || 1'($urandom_range(0, 1)));
      ch_wdata[ch*DW +: DW]   = wbeat(ch, wb);
      dma_read_valid          = rd && (mode != 1 || 1'($urandom_range(0, 1)));
      dma_read_data           = rbeat(ch, rb);
      ch_rdata_ready          = '0;
      ch_rdata_ready[ch]      = (mode != 1 || 1'($urandom_range(0, 1)));
      #1;
      if (!hdr_acc && dma_write_valid && dma_write_ready) begin
        hdr_acc = 1'b1;
        last_cyc = cyc;
      end else if (ch_wdata_valid[ch] && ch_wdata_ready[ch]) begin
        wb++;
        last_cyc = cyc;
      end
      if (ch_rdata_valid[ch] && ch_rdata_ready[ch]) begin
        rb++;
        last_cyc = cyc;
      end
      tick();
    end
    dma_write_ready = 1'b0;
    ch_wdata_valid  = '0;
    dma_read_valid  = 1'b0;
    ch_rdata_ready  = '0;
    check("done_latency", 128'(done_cyc), 128'(last_cyc + 1));
    check("beat_count", 128'(rd ? rb : wb), 128'(len));
    tick();
    check("busy_after", 128'(busy), 128'(0));
    check("done_once", 128'(done_cnt[ch] - d0), 128'(1));
    check("wq_size", 128'(wq.size()), 128'(rd ? 1 : int'(len) + 1));
    for (int i = 0; i < wq.size(); i++)
      check("wq_word", wq[i], (i == 0) ? eh : wbeat(ch, i - 1));
    check("rq_size", 128'(rq.size()), 128'(rd ? int'(len) : 0));
    for (int i = 0; i < rq.size(); i++)
      check("rq_word", rq[i], rbeat(ch, i));
  endtask

  // Zero-length writes with requests held; grant order must be (off+t) % m
  task automatic rr_run(input logic [3:0] reqs, input int n, input int off, input int m);
    int e;
    ch_len = '0;
    ch_rwn = '0;
    ch_req = reqs;
    tick();
    for (int t = 0; t < n; t++) begin
      e = (off + t) % m;
      check("rr_grant", 128'(ch_grant), 128'(1) << e);
      dma_resp = 1'b1;
      tick();
      dma_resp = 1'b0;
      dma_write_ready = 1'b1;
      tick();
      dma_write_ready = 1'b0;
      check("rr_done", 128'(ch_done), 128'(1) << e);
      if (t == n - 1) ch_req = '0;
      tick();
      check("rr_gap_idle", 128'({busy, dma_req}), 128'(0));
      if (t < n - 1) begin
        tick();
        check("rr_gap_req", 128'(dma_req), 128'(1));
      end
    end
  endtask

  initial begin
    int d1;
    rst = 1'b1;
    ch_req = '0; ch_rwn = '0; ch_host_addr = '0; ch_local_addr = '0; ch_len = '0;
    ch_wdata = '0; ch_wdata_valid = '0; ch_rdata_ready = '0;
    dma_resp = 1'b0; dma_write_ready = 1'b0; dma_read_valid = 1'b0; dma_read_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 128'({ch_grant, ch_done, ch_wdata_ready, ch_rdata_valid,
                              busy, dma_req, dma_write_valid, dma_read_ready}), 128'(0));
    rst = 1'b0;
    tick();

    xfer(0, 1'b0, 4'd3,  40'h12_3456_7890, 14'h0ABC, 1, 0);
    xfer(1, 1'b1, 4'd4,  40'h00_AAAA_5555, 14'h1234, 0, 1);
    check("rd_ch0_quiet", 128'(rv0), 128'(0));
    xfer(2, 1'b0, 4'd0,  40'hFF_0000_0001, 14'h3FFF, 0, 0);
    xfer(3, 1'b1, 4'd0,  40'h01_0203_0405, 14'h0001, 2, 0);
    xfer(0, 1'b0, 4'd6,  40'h55_6677_8899, 14'h2222, 0, 2);
    check("stall_stable", 128'(stab_err), 128'(0));
    xfer(1, 1'b0, 4'd5,  40'h0A_0B0C_0D0E, 14'h0F0F, 1, 1);
    xfer(3, 1'b0, 4'd15, 40'hC0_FFEE_0000, 14'h1111, 0, 0);
    xfer(2, 1'b1, 4'd7,  40'h77_0000_7777, 14'h0707, 0, 1);
    xfer(0, 1'b0, 4'd1,  40'h00_0000_0010, 14'h0010, 0, 0);

    // Reset in the middle of an 8-beat write on channel 1
    d1 = done_cnt[1];
    ch_rwn[1] = 1'b0;
    ch_len[1*NW +: NW] = 4'd8;
    ch_req[1] = 1'b1;
    tick();
    ch_req[1] = 1'b0;
    check("rst_grant", 128'(ch_grant), 128'(4'b0010));
    dma_resp = 1'b1;
    tick();
    dma_resp = 1'b0;
    dma_write_ready = 1'b1;
    ch_wdata_valid[1] = 1'b1;
    tick();
    tick();
    check("rst_pre_wready", 128'(ch_wdata_ready), 128'(4'b0010));
    rst = 1'b1;
    #1;
    check("rst_outs", 128'({ch_grant, ch_done, ch_wdata_ready, ch_rdata_valid,
                            busy, dma_req, dma_write_valid, dma_read_ready}), 128'(0));
    check("rst_wdata", dma_write_data, 128'(0));
    dma_write_ready = 1'b0;
    ch_wdata_valid = '0;
    tick();
    rst = 1'b0;
    tick();
    check("rst_no_done", 128'(done_cnt[1] - d1), 128'(0));

    rr_run(4'hF, 5, 0, 4);
    rr_run(4'h3, 4, 1, 2);
    check("rv_owner_only", 128'(rv_bad), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
